// File: rtl/sdp_ram.sv
// sdp_ram: simple dual-port RAM, one write port and one registered read port.
// Write-first on collision. RAM_DEBUG_DISPLAY_EN enables simulation trace.
module sdp_ram #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 4,
  parameter     TAG        = "ram"
) (
  input  logic                  clk,
  input  logic                  res,
  input  logic                  re,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] readAddr,
  input  logic [ADDR_WIDTH-1:0] writeAddr,
  input  logic [WIDTH-1:0]      dataIn,
  output logic [WIDTH-1:0]      dataOut
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_dout;

  logic             w_wr;
  logic             w_rd;
  logic             w_coll;
  logic [WIDTH-1:0] w_rdata;

  // both ports are gated off while reset is held
  assign w_wr   = we & ~res;
  assign w_rd   = re & ~res;
  assign w_coll = w_wr & w_rd & (readAddr == writeAddr);

  // same-address collision forwards the incoming word
  assign w_rdata = w_coll ? dataIn : r_mem[readAddr];

  // array write; contents are never cleared
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[writeAddr] <= dataIn;
    end
  end

  // read register: cleared by reset, holds while re is low
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_dout <= '0;
    end else if (re) begin
      r_dout <= w_rdata;
    end
  end

  assign dataOut = r_dout;

`ifdef RAM_DEBUG_DISPLAY_EN
  // trace every access, collision and read of an unwritten word
  always_ff @(posedge clk) begin
    if (w_wr) begin
      $display("[%s] write addr %0h data %0h",
               TAG, writeAddr, dataIn);
    end
    if (w_rd) begin
      $display("[%s] read addr %0h data %0h",
               TAG, readAddr, w_rdata);
      if ($isunknown(w_rdata)) begin
        $display("[%s] warning: uninitialised read addr %0h",
                 TAG, readAddr);
      end
    end
    if (w_coll) begin
      $display("[%s] read/write collision addr %0h",
               TAG, readAddr);
    end
  end
`else
  // the tag string only matters for the trace messages
  if ($bits(TAG) == 0) begin : g_no_tag
  end
`endif

endmodule

// File: tb/tb_sdp_ram.sv
// tb_sdp_ram: directed checks for sdp_ram in the 32x16 data shape
// and the 16x16 tag-array shape.
module tb_sdp_ram;

  logic        clk;
  logic        res_a, re_a, we_a;
  logic [3:0]  ra_a, wa_a;
  logic [31:0] din_a, dout_a;

  logic        res_b, re_b, we_b;
  logic [3:0]  ra_b, wa_b;
  logic [15:0] din_b, dout_b;

  int n_chk;
  int n_err;

  sdp_ram #(.WIDTH(32), .ADDR_WIDTH(4), .TAG("data")) u_a (
    .clk      (clk),
    .res      (res_a),
    .re       (re_a),
    .we       (we_a),
    .readAddr (ra_a),
    .writeAddr(wa_a),
    .dataIn   (din_a),
    .dataOut  (dout_a)
  );

  sdp_ram #(.WIDTH(16), .ADDR_WIDTH(4), .TAG("tag")) u_b (
    .clk      (clk),
    .res      (res_b),
    .re       (re_b),
    .we       (we_b),
    .readAddr (ra_b),
    .writeAddr(wa_b),
    .dataIn   (din_b),
    .dataOut  (dout_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // one edge on port set A, then idle the enables
  task automatic cyc_a(input logic re, input logic [3:0] ra,
                       input logic we, input logic [3:0] wa,
                       input logic [31:0] d);
    re_a  = re;
    ra_a  = ra;
    we_a  = we;
    wa_a  = wa;
    din_a = d;
    @(posedge clk);
    #1;
    re_a = 1'b0;
    we_a = 1'b0;
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    res_a = 1'b1; re_a = 1'b0; we_a = 1'b0;
    ra_a = '0; wa_a = '0; din_a = '0;
    res_b = 1'b1; re_b = 1'b0; we_b = 1'b0;
    ra_b = '0; wa_b = '0; din_b = '0;

    #2;
    chk("rst_init_a", dout_a, 32'h0);
    chk("rst_init_b", {16'h0, dout_b}, 32'h0);
    @(posedge clk);
    #1;
    res_a = 1'b0;
    res_b = 1'b0;

    // seed words used later
    cyc_a(0, 0, 1, 4'd11, 32'h11);
    cyc_a(0, 0, 1, 4'd7,  32'h1);
    cyc_a(0, 0, 1, 4'd9,  32'h99);
    cyc_a(1, 4'd11, 0, 0, 0);
    chk("seed_rd11", dout_a, 32'h11);

    // asynchronous reset mid-cycle
    @(posedge clk);
    #3;
    res_a = 1'b1;
    #1;
    chk("rst_async", dout_a, 32'h0);
    re_a = 1'b1; ra_a = 4'd11;
    we_a = 1'b1; wa_a = 4'd11; din_a = 32'hBAD;
    @(posedge clk);
    #1;
    chk("rst_hold1", dout_a, 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold2", dout_a, 32'h0);
    re_a = 1'b0; we_a = 1'b0;
    res_a = 1'b0;
    cyc_a(1, 4'd11, 0, 0, 0);
    chk("rst_nowrite", dout_a, 32'h11);

    // read of a never-written word; value undefined, not checked
    cyc_a(1, 4'd3, 0, 0, 0);

    // write then read
    cyc_a(0, 0, 1, 4'd5, 32'hDEADBEEF);
    cyc_a(1, 4'd5, 0, 0, 0);
    chk("wr_rd5", dout_a, 32'hDEADBEEF);

    // hold while re is low, with writes to the same word
    for (int i = 0; i < 10; i++) begin
      cyc_a(0, 4'd5, 1, 4'd5, 32'h12345678);
      if (i == 0 || i == 9) chk("hold", dout_a, 32'hDEADBEEF);
    end
    cyc_a(1, 4'd5, 0, 0, 0);
    chk("hold_rd5", dout_a, 32'h12345678);

    // collision is write-first
    cyc_a(1, 4'd7, 1, 4'd7, 32'hA5A5A5A5);
    chk("coll", dout_a, 32'hA5A5A5A5);
    cyc_a(1, 4'd7, 0, 0, 0);
    chk("coll_rd7", dout_a, 32'hA5A5A5A5);

    // independent ports on one edge
    cyc_a(1, 4'd9, 1, 4'd2, 32'h22);
    chk("indep_rd9", dout_a, 32'h99);
    cyc_a(1, 4'd2, 0, 0, 0);
    chk("indep_rd2", dout_a, 32'h22);

    // tag-array shape: fill back-to-back
    for (int i = 0; i < 16; i++) begin
      we_b  = 1'b1;
      wa_b  = 4'(i);
      din_b = 16'(i * 3);
      @(posedge clk);
      #1;
    end
    we_b = 1'b0;

    // read back-to-back, reset mid-burst
    for (int i = 0; i < 16; i++) begin
      re_b = 1'b1;
      ra_b = 4'(i);
      @(posedge clk);
      #1;
      chk("burst", {16'h0, dout_b}, 32'(i * 3));
      if (i == 8) begin
        #2;
        res_b = 1'b1;
        #1;
        chk("burst_rst", {16'h0, dout_b}, 32'h0);
        @(posedge clk);
        #1;
        chk("burst_rst_hold", {16'h0, dout_b}, 32'h0);
        res_b = 1'b0;
      end
    end
    re_b = 1'b1;
    ra_b = 4'd4;
    @(posedge clk);
    #1;
    re_b = 1'b0;
    chk("post_rst_rd4", {16'h0, dout_b}, 32'd12);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sdp_ram.md
Name: sdp_ram

Overview:
- Simple dual-port synchronous RAM: one write port and one registered read port, both on a single clock.
- Used as the data array and the tag array of the cache.
- Width, depth and a debug tag string are set by parameters.
- Memory contents are not cleared by reset; the client initialises them by writing, for example the cache's reset sweep over the tag array.

Parameters:
- WIDTH, 32, data word width in bits (≥1).
- ADDR_WIDTH, 4, address width in bits; depth = 2**ADDR_WIDTH words.
- TAG, "ram", string prefix used in debug messages only; no functional effect.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- res  input  1  asynchronous, active-high reset.
- re  input  1  read enable.
- we  input  1  write enable.
- readAddr  input  ADDR_WIDTH  read word address.
- writeAddr  input  ADDR_WIDTH  write word address.
- dataIn  input  WIDTH  write data.
- dataOut  output  WIDTH  registered read data.

Behaviour:
- One clock (clk). Reset res is asynchronous and active-high.
- Storage: 2**ADDR_WIDTH words of WIDTH bits. Every address value is in range, so no bounds logic is needed.
- Reset:
  - res high forces dataOut to 0 immediately, without waiting for a clock edge, and dataOut stays 0 while res is high.
  - The array is not modified by reset; its contents after power-up are undefined (X in simulation).
  - re and we are ignored while res is high.
  - A reset asserted mid-operation aborts any pending read update; no write occurs on an edge where res is high.
- Write, no handshake:
  - On a rising edge with we=1, mem[writeAddr] <= dataIn.
  - The write is visible to reads issued on the following edge.
- Read:
  - Latency is 1 cycle. On a rising edge with re=1, dataOut <= mem[readAddr].
  - The value is valid from just after that edge until the next edge with re=1.
  - With re=0, dataOut holds its last value indefinitely. Clients rely on this hold, e.g. the cache reads the tag in one cycle and uses it in the next.
- Read/write collision (re=1, we=1, readAddr==writeAddr, same edge):
  - Write-first: dataOut takes the new dataIn value, and the array is also updated.
  - With different addresses, both operations proceed independently.
- re and we may be asserted on consecutive or identical cycles without restriction; the RAM is fully pipelined at one access per port per cycle.
- No X propagation guard on inputs is required. X on dataIn is written as X; an X address with we=1 is undefined in simulation.

Optional Feature:
- Macro RAM_DEBUG_DISPLAY_EN.
- When defined, the block prints simulation $display messages with the "[TAG]" prefix:
  - on every write edge: write address and data;
  - on every read edge: read address and returned data;
  - on every collision: a "read/write collision" note.
- Also when defined, an "uninitialised read" warning is printed if the word read contains X.
- When undefined, no display code is elaborated and behaviour is identical otherwise.
- The feature is synthesis-neutral.

Test Plan:
- Reset with res=1 mid-cycle (asynchronous) → dataOut becomes 0 at once and stays 0 while res=1. Then release res, issue re=1 at address 3 with no prior write → dataOut becomes X (undefined).
- Write then read: we=1, writeAddr=5, dataIn=0xDEADBEEF; next cycle re=1, readAddr=5 → dataOut=0xDEADBEEF one cycle after the read edge.
- Hold: after reading 0xDEADBEEF, keep re=0 for 10 cycles while writing 0x12345678 to address 5 → dataOut stays 0xDEADBEEF. Then re=1 at address 5 → dataOut=0x12345678.
- Collision: previous content of address 7 is 0x1; re=1, we=1, both addresses 7, dataIn=0xA5A5A5A5 → dataOut=0xA5A5A5A5, and a later read of address 7 returns 0xA5A5A5A5.
- Independent ports: same edge with we at address 2 (data 0x22) and re at address 9, where address 9 holds 0x99 → dataOut=0x99, and a later read of address 2 returns 0x22.
- Parameter sweep: WIDTH=16, ADDR_WIDTH=4 (the cache tag array shape):
  - write addresses 0..15 with value index×3 in back-to-back cycles, then read them back-to-back;
  - each dataOut matches one cycle after its read edge.
  - Assert res during the read burst → dataOut becomes 0 immediately, and a post-reset read of address 4 still returns 12.
